clock_display_scan: RTL

Multiplexed six-digit seven-segment scan driver that consumes the BCD `hour`/`min`/`sec` bytes produced by the digital clock counter and drives a common-segment LED display. Each digit is shown in turn. Every `SCAN_DIV` clocks the block advances one digit. It snapshots the time at the start of each frame so that a counter rollover cannot tear a frame. It sits between the clock counter and the board pins.

---
 rtl/clock_display_scan.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scan driver for an hh.mm.ss clock.
// Time is snapshotted at each frame start so a rollover cannot tear a frame.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig,
  output logic       frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    mn_q, mn_d;
  logic [7:0]    sc_q, sc_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    dig_q, dig_d;
  logic          frame_q, frame_d;
  logic          tick, wrap;
  logic [3:0]    nib;
  logic [6:0]    pat;

  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == 3'd5);
    cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    hr_d = hr_q;
    mn_d = mn_q;
    sc_d = sc_q;
    if (wrap) begin
      hr_d = hour;
      mn_d = min;
      sc_d = sec;
    end
  end

  // Digit select uses next-state values so digit 0 sees the fresh snapshot
  always_comb begin
    case (idx_d)
      3'd0:    nib = sc_d[3:0];
      3'd1:    nib = sc_d[7:4];
      3'd2:    nib = mn_d[3:0];
      3'd3:    nib = mn_d[7:4];
      3'd4:    nib = hr_d[3:0];
      default: nib = hr_d[7:4];
    endcase
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
  end

  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    dig_d   = dig_q;
    frame_d = 1'b0;
    if (!en) begin
      seg_d = '0;
      dp_d  = 1'b0;
      dig_d = '0;
    end else if (tick) begin
      seg_d = pat;
      if (idx_d == 3'd5 && blank_lead && hr_d[7:4] == 4'd0) seg_d = '0;
      dp_d    = (idx_d == 3'd2 || idx_d == 3'd4) && !sc_d[0];
      dig_d   = 6'd1 << idx_d;
      frame_d = wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd5;
      hr_q    <= '0;
      mn_q    <= '0;
      sc_q    <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hr_q    <= hr_d;
      mn_q    <= mn_d;
      sc_q    <= sc_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp    = dp_q ^ SEG_ACTIVE_LOW;
  assign dig   = dig_q ^ {6{DIG_ACTIVE_LOW}};
  assign frame = frame_q;

endmodule
